// File: rtl/stage_if_pf_if.sv
// Fetch-stage bundle: memory port, icache lookup/fill, branch redirect and ID handoff.
interface stage_if_pf_if #(
   parameter int MEM_BYTES = 1
);
   logic                   mem_req_o;
   logic                   mem_gnt_i;
   logic [31:0]            mem_a_o;
   logic [8*MEM_BYTES-1:0] mem_din_i;
   logic [31:0]            icache_raddr_o;
   logic                   icache_hit_i;
   logic [31:0]            icache_inst_i;
   logic                   icache_we_o;
   logic [31:0]            icache_waddr_o;
   logic [31:0]            icache_winst_o;
   logic                   branch_flag_i;
   logic [31:0]            branch_addr_i;
   logic                   inst_valid_o;
   logic [31:0]            inst_o;
   logic [31:0]            pc_o;
   logic                   id_ready_i;
   logic                   pred_taken_o;

   modport master (
      output mem_req_o, mem_a_o,
      input  mem_gnt_i, mem_din_i,
      output icache_raddr_o,
      input  icache_hit_i, icache_inst_i,
      output icache_we_o, icache_waddr_o,
      output icache_winst_o,
      input  branch_flag_i, branch_addr_i,
      output inst_valid_o, inst_o, pc_o,
      output pred_taken_o,
      input  id_ready_i
   );

   modport slave (
      input  mem_req_o, mem_a_o,
      output mem_gnt_i, mem_din_i,
      input  icache_raddr_o,
      output icache_hit_i, icache_inst_i,
      input  icache_we_o, icache_waddr_o,
      input  icache_winst_o,
      output branch_flag_i, branch_addr_i,
      input  inst_valid_o, inst_o, pc_o,
      input  pred_taken_o,
      output id_ready_i
   );
endinterface

// File: rtl/stage_if_pf.sv
// Fetch stage with DEPTH-entry prefetch queue, icache lookup and memory refill.
// Define IF_PREDICT_EN to follow JAL targets and mark entries predicted taken.
module stage_if_pf #(
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int          DEPTH     = 4,
   parameter int          MEM_BYTES = 1
) (
   input logic           clk,
   input logic           rst,
   stage_if_pf_if.master io
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = 8 * MEM_BYTES;
   localparam int N  = 4 / MEM_BYTES;
   localparam logic [AW:0] FULL  = DEPTH[AW:0];
   localparam logic [2:0]  BEATS = N[2:0];
   localparam logic [2:0]  LAST  = 3'(N - 1);
   localparam logic [1:0]  IDLE   = 2'd0;
   localparam logic [1:0]  LOOKUP = 2'd1;
   localparam logic [1:0]  MEM    = 2'd2;

   logic [1:0]    state;
   logic [31:0]   fpc;
   logic [31:0]   wbuf;
   logic [31:0]   word;
   logic [31:0]   enq_word;
   logic [31:0]   npc;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;
   logic [31:0]   inst_q [DEPTH];
   logic [31:0]   pc_q [DEPTH];
   logic [2:0]    issued;
   logic [2:0]    recv;
   logic          pend;
   logic          issue;
   logic          capture;
   logic          done;
   logic          enq;
   logic          deq;
   logic          valid;
   logic          branch;

   assign branch   = io.branch_flag_i;
   assign valid    = count != '0;
   assign deq      = valid & io.id_ready_i;
   assign issue    = state == MEM && io.mem_gnt_i
                     && issued < BEATS;
   // A beat lands only if grant held in both its issue and return cycles
   assign capture  = state == MEM && io.mem_gnt_i && pend;
   assign done     = capture && recv == LAST;
   assign enq      = (state == LOOKUP && io.icache_hit_i)
                     || done;
   assign enq_word = state == LOOKUP ? io.icache_inst_i
                                     : word;

   assign io.mem_a_o = issue
      ? fpc + 32'(issued) * MEM_BYTES
      : 32'h0;
   assign io.inst_valid_o = valid;
   assign io.inst_o       = inst_q[head];
   assign io.pc_o         = pc_q[head];

   always_comb begin
      word = wbuf;
      for (int k = 0; k < N; k++)
         if (capture && recv == 3'(k))
            word[k*BW +: BW] = io.mem_din_i;
   end

`ifdef IF_PREDICT_EN
   logic        pred_q [DEPTH];
   logic        jal;
   logic [31:0] jimm;

   assign jal  = enq_word[6:0] == 7'b1101111;
   assign jimm = {{11{enq_word[31]}}, enq_word[31],
                  enq_word[19:12], enq_word[20],
                  enq_word[30:21], 1'b0};
   assign npc  = jal ? (fpc + jimm) & ~32'h3
                     : fpc + 32'd4;
   assign io.pred_taken_o = pred_q[head];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            pred_q[i] <= 1'b0;
      end else if (!branch && enq) begin
         pred_q[tail] <= jal;
      end
   end
`else
   assign npc = fpc + 32'd4;
   assign io.pred_taken_o = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= IDLE;
         fpc               <= RESET_PC;
         head              <= '0;
         tail              <= '0;
         count             <= '0;
         issued            <= '0;
         recv              <= '0;
         pend              <= 1'b0;
         wbuf              <= '0;
         io.mem_req_o      <= 1'b0;
         io.icache_raddr_o <= '0;
         io.icache_we_o    <= 1'b0;
         io.icache_waddr_o <= '0;
         io.icache_winst_o <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         // Fill write happens even when a redirect kills the enqueue
         io.icache_we_o <= done;
         if (done) begin
            io.icache_waddr_o <= fpc;
            io.icache_winst_o <= word;
         end
         if (branch) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            state        <= IDLE;
            fpc          <= io.branch_addr_i & ~32'h3;
            io.mem_req_o <= 1'b0;
            issued       <= '0;
            recv         <= '0;
            pend         <= 1'b0;
         end else begin
            if (enq) begin
               inst_q[tail] <= enq_word;
               pc_q[tail]   <= fpc;
               tail         <= tail + 1'b1;
            end
            if (deq)
               head <= head + 1'b1;
            if (enq && !deq)
               count <= count + 1'b1;
            else if (!enq && deq)
               count <= count - 1'b1;
            case (state)
               IDLE: begin
                  if (count < FULL) begin
                     io.icache_raddr_o <= fpc;
                     state             <= LOOKUP;
                  end
               end
               LOOKUP: begin
                  if (io.icache_hit_i) begin
                     fpc   <= npc;
                     state <= IDLE;
                  end else begin
                     io.mem_req_o <= 1'b1;
                     issued       <= '0;
                     recv         <= '0;
                     pend         <= 1'b0;
                     state        <= MEM;
                  end
               end
               MEM: begin
                  if (!io.mem_gnt_i) begin
                     issued <= recv;
                     pend   <= 1'b0;
                  end else begin
                     pend <= issue;
                     if (issue)
                        issued <= issued + 3'd1;
                     if (capture) begin
                        wbuf <= word;
                        recv <= recv + 3'd1;
                     end
                     if (done) begin
                        io.mem_req_o <= 1'b0;
                        fpc          <= npc;
                        state        <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
